// File: rtl/intersection_phase_scheduler_if.sv
// Signal bundle between the intersection phase scheduler and its controller:
// time base, demand sensors and pedestrian button in; lamp drive and debug state out.
interface intersection_phase_scheduler_if;
    logic        tick;
    logic [3:0]  req;
    logic        ped_req;
    logic [11:0] light;
    logic        walk;
    logic [1:0]  phase;
    logic [2:0]  state;

    modport master (
        output tick, req, ped_req,
        input  light, walk, phase, state
    );

    modport slave (
        input  tick, req, ped_req,
        output light, walk, phase, state
    );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Four-phase round-robin signal scheduler with minimum/maximum green, yellow,
// all-red clearance and a latched pedestrian WALK phase, timed in ticks.
module intersection_phase_scheduler #(
    parameter int unsigned MIN_GREEN = 4,
    parameter int unsigned MAX_GREEN = 10,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned WALK_T    = 6,
    parameter int unsigned TW        = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    intersection_phase_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        ST_GREEN   = 3'd0,
        ST_YELLOW  = 3'd1,
        ST_ALL_RED = 3'd2,
        ST_WALK    = 3'd3
    } state_t;

    localparam logic [TW:0]   MIN_GREEN_N  = (TW+1)'(MIN_GREEN);
    localparam logic [TW:0]   MAX_GREEN_N  = (TW+1)'(MAX_GREEN);
    localparam logic [TW-1:0] MAX_GREEN_T  = TW'(MAX_GREEN);
    localparam logic [TW-1:0] YELLOW_LAST  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ALLRED_LAST  = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] WALK_LAST    = TW'(WALK_T - 1);
    localparam logic [TW-1:0] TIMER_ZERO   = {TW{1'b0}};
    localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
    localparam logic [11:0]   LAMPS_ALLRED = 12'h924;

    // Round-robin pick: first requester after the current phase, the current
    // phase itself last; phase 0 (home rest) when nobody requests.
    function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] cur);
        logic [1:0] pick;
        logic [1:0] cand;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand  = cur + 2'(k);
            pick  = (!found && req_v[cand]) ? cand : pick;
            found = found | req_v[cand];
        end
        return pick;
    endfunction

    function automatic logic [11:0] lamp_decode(input state_t st, input logic [1:0] ph);
        logic [11:0] l;
        l = LAMPS_ALLRED;
        case (st)
            ST_GREEN:  l[{2'b00, ph} * 4'd3 +: 3] = 3'b001;
            ST_YELLOW: l[{2'b00, ph} * 4'd3 +: 3] = 3'b010;
            default:   l = LAMPS_ALLRED;
        endcase
        return l;
    endfunction

    state_t        state_r, state_nxt_s;
    logic [TW-1:0] timer_r, timer_nxt_s;
    logic [1:0]    phase_r, phase_nxt_s;
    logic          ped_pending_r, ped_pending_nxt_s;
    logic          from_walk_r, from_walk_nxt_s;
    logic [11:0]   light_r;
    logic          walk_r;

    logic          ped_eff_s;
    logic          competing_s;
    logic [TW:0]   green_n_s;
    logic [3:0]    phase_onehot_s;

    // A button press in this very cycle counts toward the decision taken now.
    assign ped_eff_s      = ped_pending_r | bus.ped_req;
    assign phase_onehot_s = 4'b0001 << phase_r;
    assign competing_s    = ped_eff_s | (|(bus.req & ~phase_onehot_s));
    assign green_n_s      = {1'b0, timer_r} + (TW+1)'(1);

    // Next-state, interval timer and pedestrian latch update.
    always_comb begin
        state_nxt_s       = state_r;
        timer_nxt_s       = timer_r;
        phase_nxt_s       = phase_r;
        from_walk_nxt_s   = from_walk_r;
        ped_pending_nxt_s = ped_eff_s;
        if (bus.tick) begin
            case (state_r)
                ST_GREEN: begin
                    if (competing_s && ((green_n_s >= MAX_GREEN_N) ||
                                        ((green_n_s >= MIN_GREEN_N) && !bus.req[phase_r]))) begin
                        state_nxt_s = ST_YELLOW;
                        timer_nxt_s = TIMER_ZERO;
                    end else if (green_n_s >= MAX_GREEN_N) begin
                        timer_nxt_s = MAX_GREEN_T;
                    end else begin
                        timer_nxt_s = green_n_s[TW-1:0];
                    end
                end
                ST_YELLOW: begin
                    if (timer_r == YELLOW_LAST) begin
                        state_nxt_s     = ST_ALL_RED;
                        timer_nxt_s     = TIMER_ZERO;
                        from_walk_nxt_s = 1'b0;
                    end else begin
                        timer_nxt_s = timer_r + TIMER_ONE;
                    end
                end
                ST_WALK: begin
                    if (timer_r == WALK_LAST) begin
                        state_nxt_s     = ST_ALL_RED;
                        timer_nxt_s     = TIMER_ZERO;
                        from_walk_nxt_s = 1'b1;
                    end else begin
                        timer_nxt_s = timer_r + TIMER_ONE;
                    end
                end
                ST_ALL_RED: begin
                    if (timer_r == ALLRED_LAST) begin
                        timer_nxt_s = TIMER_ZERO;
                        // Back-to-back WALKs are never granted; traffic gets a turn first.
                        if (ped_eff_s && !from_walk_r) begin
                            state_nxt_s       = ST_WALK;
                            ped_pending_nxt_s = 1'b0;
                        end else begin
                            state_nxt_s = ST_GREEN;
                            phase_nxt_s = rr_pick(bus.req, phase_r);
                        end
                    end else begin
                        timer_nxt_s = timer_r + TIMER_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_ALL_RED;
                    timer_nxt_s = TIMER_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State registers; lamps are registered from the next state so they track it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_ALL_RED;
            timer_r       <= TIMER_ZERO;
            phase_r       <= 2'd0;
            ped_pending_r <= 1'b0;
            from_walk_r   <= 1'b0;
            light_r       <= LAMPS_ALLRED;
            walk_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            timer_r       <= timer_nxt_s;
            phase_r       <= phase_nxt_s;
            ped_pending_r <= ped_pending_nxt_s;
            from_walk_r   <= from_walk_nxt_s;
            light_r       <= lamp_decode(state_nxt_s, phase_nxt_s);
            walk_r        <= (state_nxt_s == ST_WALK);
        end
    end

    assign bus.light = light_r;
    assign bus.walk  = walk_r;
    assign bus.phase = phase_r;
    assign bus.state = state_r;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a tick-counting reference model of the scheduling rules.
module tb_intersection_phase_scheduler;

    localparam int MIN_G = 4;
    localparam int MAX_G = 10;
    localparam int YEL   = 3;
    localparam int AR    = 2;
    localparam int WLK   = 6;

    localparam int M_GREEN  = 0;
    localparam int M_YELLOW = 1;
    localparam int M_ALLRED = 2;
    localparam int M_WALK   = 3;

    logic clk = 1'b0;
    logic rst;

    intersection_phase_scheduler_if bus();

    intersection_phase_scheduler #(
        .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_T(YEL),
        .ALLRED_T(AR), .WALK_T(WLK), .TW(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: current interval, ticks spent in it, phase, latch.
    int m_mode  = M_ALLRED;
    int m_cnt   = 0;
    int m_phase = 0;
    bit m_pend  = 1'b0;
    int m_prev  = M_ALLRED;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_next(input bit [3:0] rq, input int cur);
        for (int k = 1; k <= 4; k++) begin
            if (rq[(cur + k) % 4]) return (cur + k) % 4;
        end
        return 0;
    endfunction

    task automatic model_step(input bit r, input bit t, input bit [3:0] rq, input bit pr);
        bit pend_eff;
        bit comp;
        int n;
        if (r) begin
            m_mode = M_ALLRED; m_cnt = 0; m_phase = 0; m_pend = 1'b0; m_prev = M_ALLRED;
            return;
        end
        pend_eff = m_pend || pr;
        m_pend   = pend_eff;
        if (!t) return;
        case (m_mode)
            M_GREEN: begin
                n    = m_cnt + 1;
                comp = pend_eff || ((rq & ~(4'b0001 << m_phase)) != 4'b0000);
                if (comp && (n >= MAX_G || (n >= MIN_G && !rq[m_phase]))) begin
                    m_mode = M_YELLOW; m_cnt = 0;
                end else begin
                    m_cnt = (n > MAX_G) ? MAX_G : n;
                end
            end
            M_YELLOW, M_WALK: begin
                m_cnt++;
                if (m_cnt == ((m_mode == M_YELLOW) ? YEL : WLK)) begin
                    m_prev = m_mode; m_mode = M_ALLRED; m_cnt = 0;
                end
            end
            default: begin
                m_cnt++;
                if (m_cnt == AR) begin
                    m_cnt = 0;
                    if (pend_eff && m_prev != M_WALK) begin
                        m_mode = M_WALK; m_pend = 1'b0;
                    end else begin
                        m_mode = M_GREEN; m_phase = pick_next(rq, m_phase);
                    end
                end
            end
        endcase
    endtask

    function automatic logic [11:0] exp_light();
        logic [11:0] l;
        l = 12'h924;
        for (int i = 0; i < 4; i++) begin
            if (i == m_phase && m_mode == M_GREEN)  l[3*i +: 3] = 3'b001;
            if (i == m_phase && m_mode == M_YELLOW) l[3*i +: 3] = 3'b010;
        end
        return l;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step(rst, bus.tick, bus.req, bus.ped_req);
        #1;
        check_eq("light", {20'd0, bus.light}, {20'd0, exp_light()});
        check_eq("walk",  {31'd0, bus.walk}, (m_mode == M_WALK) ? 32'd1 : 32'd0);
        check_eq("phase", {30'd0, bus.phase}, m_phase);
    endtask

    logic [11:0] frozen_exp;
    int          waited;

    initial begin
        rst = 1'b1; bus.tick = 1'b1; bus.req = 4'b0000; bus.ped_req = 1'b0;
        repeat (3) cycle();
        check_eq("rst_light", {20'd0, bus.light}, 32'h924);
        check_eq("rst_walk",  {31'd0, bus.walk}, 32'd0);
        check_eq("rst_phase", {30'd0, bus.phase}, 32'd0);

        rst = 1'b0;
        cycle();
        check_eq("start_allred", {20'd0, bus.light}, 32'h924);
        cycle();
        check_eq("start_home", {20'd0, bus.light}, 32'h921);
        repeat (50) cycle();
        check_eq("home_hold", {20'd0, bus.light}, 32'h921);

        bus.req = 4'b0100;
        cycle();
        check_eq("sat_yellow", {20'd0, bus.light}, 32'h922);
        repeat (3) cycle();
        check_eq("sat_allred", {20'd0, bus.light}, 32'h924);
        repeat (2) cycle();
        check_eq("green2_light", {20'd0, bus.light}, 32'h864);
        check_eq("green2_phase", {30'd0, bus.phase}, 32'd2);

        bus.req = 4'b0010;
        repeat (3) cycle();
        check_eq("min_green_hold", {20'd0, bus.light}, 32'h864);
        cycle();
        check_eq("min_green_end", {20'd0, bus.light}, 32'h8A4);

        bus.req = 4'b0110;
        repeat (5) cycle();
        check_eq("max_green_start", {20'd0, bus.light}, 32'h90C);
        repeat (9) cycle();
        check_eq("max_green_hold", {20'd0, bus.light}, 32'h90C);
        cycle();
        check_eq("max_green_end", {20'd0, bus.light}, 32'h914);

        bus.req = 4'b1011;
        repeat (80) cycle();

        bus.req = 4'b0000;
        repeat (40) cycle();
        bus.ped_req = 1'b1;
        cycle();
        bus.ped_req = 1'b0;
        waited = 0;
        while (m_mode != M_WALK && waited < 60) begin cycle(); waited++; end
        check_eq("reach_walk", {31'd0, bus.walk}, 32'd1);
        bus.ped_req = 1'b1;
        cycle();
        bus.ped_req = 1'b0;
        repeat (60) cycle();

        bus.req = 4'b0100;
        waited = 0;
        while (m_mode != M_YELLOW && waited < 60) begin cycle(); waited++; end
        check_eq("reach_yellow", (m_mode == M_YELLOW) ? 32'd1 : 32'd0, 32'd1);
        frozen_exp = exp_light();
        bus.tick = 1'b0;
        repeat (100) cycle();
        check_eq("freeze", {20'd0, bus.light}, {20'd0, frozen_exp});

        bus.ped_req = 1'b1;
        cycle();
        bus.ped_req = 1'b0;
        bus.tick = 1'b1;
        bus.req = 4'b0000;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("midrst_light", {20'd0, bus.light}, 32'h924);
        check_eq("midrst_walk",  {31'd0, bus.walk}, 32'd0);
        check_eq("midrst_phase", {30'd0, bus.phase}, 32'd0);
        repeat (2) cycle();
        check_eq("midrst_home", {20'd0, bus.light}, 32'h921);
        check_eq("midrst_nowalk", {31'd0, bus.walk}, 32'd0);

        for (int i = 0; i < 4000; i++) begin
            bus.tick    = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 9) == 0) bus.req = 4'($urandom);
            bus.ped_req = ($urandom_range(0, 99) < 4);
            rst         = ($urandom_range(0, 999) < 3);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
